// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use and branch-operand stalls, taken-branch flush,
// data-memory wait freeze with fatal timeout, and saturating stall/flush event counters.
`timescale 1ns/1ps
module hazard_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W          = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       if_id_rs1,
   input  logic [4:0]       if_id_rs2,
   input  logic             if_id_uses_rs1,
   input  logic             if_id_uses_rs2,
   input  logic             if_id_is_branch,
   input  logic [4:0]       id_ex_rd,
   input  logic             id_ex_reg_write,
   input  logic             id_ex_mem_read,
   input  logic [4:0]       ex_mem_rd,
   input  logic             ex_mem_reg_write,
   input  logic             ex_mem_mem_read,
   input  logic             branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_write_en,
   output logic             if_id_write_en,
   output logic             id_ex_bubble,
   output logic             if_id_flush,
   output logic             pipe_freeze,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic             mem_timeout
);

   localparam int unsigned       WAIT_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {StRun, StMemWait, StTimeout} state_e;

   state_e            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d, wait_inc;
   logic              ex_match, mem_match, load_use, br_hazard, stall, freeze;

   // x0 is hardwired, so a zero destination never creates a dependency
   assign ex_match  = (id_ex_rd != 5'd0) &&
                      ((if_id_uses_rs1 && (id_ex_rd == if_id_rs1)) ||
                       (if_id_uses_rs2 && (id_ex_rd == if_id_rs2)));
   assign mem_match = (ex_mem_rd != 5'd0) &&
                      ((if_id_uses_rs1 && (ex_mem_rd == if_id_rs1)) ||
                       (if_id_uses_rs2 && (ex_mem_rd == if_id_rs2)));
   assign load_use  = id_ex_mem_read && ex_match;
   assign br_hazard = if_id_is_branch &&
                      ((id_ex_reg_write && ex_match) || (ex_mem_mem_read && mem_match));
   assign stall     = load_use || br_hazard;
   assign wait_inc  = wait_q + WAIT_W'(1);

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      freeze  = 1'b0;
      unique case (state_q)
         StRun: begin
            wait_d = '0;
            if (mem_req && !mem_ready) begin
               freeze  = 1'b1;
               state_d = StMemWait;
            end
         end
         StMemWait: begin
            if (mem_ready) begin
               state_d = StRun;
               wait_d  = '0;
            end else begin
               freeze = 1'b1;
               wait_d = wait_inc;
               if (wait_inc == WAIT_MAX) state_d = StTimeout;
            end
         end
         StTimeout: freeze = 1'b1;
         default:   state_d = StRun;
      endcase
   end

   // Priority freeze > stall > flush; reset forces the free-running pattern
   always_comb begin
      pc_write_en    = 1'b1;
      if_id_write_en = 1'b1;
      id_ex_bubble   = 1'b0;
      if_id_flush    = 1'b0;
      pipe_freeze    = 1'b0;
      if (!rst) begin
         if (freeze) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            pipe_freeze    = 1'b1;
         end else if (stall) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_bubble   = 1'b1;
         end else if (branch_taken && (state_q == StRun)) begin
            if_id_flush = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StRun;
         wait_q      <= '0;
         stall_cnt   <= '0;
         flush_cnt   <= '0;
         mem_timeout <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         if ((pipe_freeze || id_ex_bubble) && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
         if (if_id_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
         if (state_d == StTimeout) mem_timeout <= 1'b1;
      end
   end

endmodule
